// File: rtl/pipe_add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding, result
// flags and segment-width helper.
package pipe_add_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;

  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_add_sub_add_seg.sv
// Combinational W-bit ripple segment; also exposes the carry into its MSB so
// the top segment can derive signed overflow.
module add_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic cy;

  always_comb begin
    cy     = cin_i;
    s_o    = '0;
    cmsb_o = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) cmsb_o = cy;
      s_o[i] = a_i[i] ^ b_i[i] ^ cy;
      cy     = (a_i[i] & b_i[i]) | (cy & (a_i[i] ^ b_i[i]));
    end
    cout_o = cy;
  end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement add/sub, one SEG-bit ripple segment per stage,
// global-stall valid/ready. Define PIPE_ADD_SUB_SAT_EN for saturating results.
module pipe_add_sub
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             op_sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int SEG = seg_w(WIDTH, STAGES);
  localparam int L   = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_cfg_err
    $error("pipe_add_sub: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end

  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_nx;
  logic [STAGES-1:0]            c_q, c_in, vld_q, vld_in;
  logic [STAGES-1:0][SEG-1:0]   seg_s;
  logic [STAGES-1:0]            seg_co, seg_cm;
  logic [WIDTH-1:0]             sum_d, sum_q;
  flags_t                       flg_d, flg_q;
  logic                         advance;

  assign advance = out_ready_i || !vld_q[L];

  // Stage k sees the operands/carry/partial sum registered by stage k-1.
  always_comb begin
    a_in[0]   = a_i;
    b_in[0]   = (op_sub_i == OP_SUB) ? ~b_i : b_i;
    c_in[0]   = (op_sub_i == OP_SUB);
    s_in[0]   = '0;
    vld_in[0] = in_valid_i;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = c_q[k-1];
      s_in[k]   = s_q[k-1];
      vld_in[k] = vld_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_seg #(.W(SEG)) u_seg (
      .a_i    (a_in[k][k*SEG +: SEG]),
      .b_i    (b_in[k][k*SEG +: SEG]),
      .cin_i  (c_in[k]),
      .s_o    (seg_s[k]),
      .cout_o (seg_co[k]),
      .cmsb_o (seg_cm[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nx[k]                = s_in[k];
      s_nx[k][k*SEG +: SEG]  = seg_s[k];
    end
  end

  // Overflow: carry into the MSB differs from carry out of it.
  always_comb begin
    flg_d.carry    = seg_co[L];
    flg_d.overflow = seg_co[L] ^ seg_cm[L];
    sum_d          = s_nx[L];
`ifdef PIPE_ADD_SUB_SAT_EN
    if (flg_d.overflow)
      sum_d = a_in[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    flg_d.zero = ~|sum_d;
  end

  // Data registers load only behind a valid beat, so bubbles leave them untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      sum_q <= '0;
      flg_q <= '0;
    end else if (advance) begin
      vld_q <= vld_in;
      for (int k = 0; k < STAGES; k++) begin
        if (vld_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          c_q[k] <= seg_co[k];
          s_q[k] <= s_nx[k];
        end
      end
      if (vld_in[L]) begin
        sum_q <= sum_d;
        flg_q <= flg_d;
      end
    end
  end

  // Last-stage skew registers and lower-segment MSB carries have no reader.
  logic unused_ok;
  assign unused_ok = ^{a_q[L], b_q[L], s_q[L], c_q[L], seg_cm};

  assign in_ready_o  = advance;
  assign out_valid_o = vld_q[L];
  assign sum_o       = sum_q;
  assign carry_out_o = flg_q.carry;
  assign overflow_o  = flg_q.overflow;
  assign zero_o      = flg_q.zero;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: directed vector table, backpressure pattern, random
// traffic against an arithmetic reference model, and mid-flight reset.
module tb_pipe_add_sub;

  localparam int W = 32;
  localparam int S = 4;
`ifdef PIPE_ADD_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         c, o, z;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub;
    logic [W-1:0] es;
    logic         ec, eo, ez;
  } vec_t;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, op_sub = 1'b0;
  logic         out_valid, out_ready = 1'b1;
  logic         carry_out, overflow, zero;
  logic [W-1:0] a = '0, b = '0, sum;

  int   n_tests = 0, n_fail = 0, cyc = 0;
  bit   chk_lat = 1'b0, hold_prev = 1'b0, done = 1'b0;
  logic [W-1:0] p_sum;
  logic [2:0]   p_flg;
  exp_t         mon_e;
  exp_t         exp_q[$];
  vec_t         tbl[10];

  pipe_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .op_sub_i    (op_sub),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .carry_out_o (carry_out),
    .overflow_o  (overflow),
    .zero_o      (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t           e;
    longint         sx, sy, r;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    r  = s ? sx - sy : sx + sy;
    e.o = (r > ((longint'(1) << (W-1)) - 1)) || (r < -(longint'(1) << (W-1)));
    e.c = s ? (x >= y) : (((ux + uy) >> W) != 0);
    e.sum = r[W-1:0];
`ifdef PIPE_ADD_SUB_SAT_EN
    if (e.o) e.sum = (r > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    e.z   = (e.sum == '0);
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard, hold-stability and in_ready rule, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", sum, p_sum);
        chk("hold_flags", {carry_out, overflow, zero}, p_flg);
      end
      hold_prev = out_valid && !out_ready;
      p_sum     = sum;
      p_flg     = {carry_out, overflow, zero};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("sum", sum, mon_e.sum);
          chk("carry_out", carry_out, mon_e.c);
          chk("overflow", overflow, mon_e.o);
          chk("zero", zero, mon_e.z);
          if (chk_lat) chk("latency", cyc - mon_e.cyc, S);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input exp_t e);
    int n = 0;
    a = ta; b = tb; op_sub = ts; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.cyc = cyc;
        exp_q.push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        chk("accept_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [W-1:0] ra, rb;
    logic         rs;
    ra = pick(); rb = pick(); rs = 1'($urandom_range(1));
    send(ra, rb, rs, model(ra, rb, rs));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // mode 0: out_ready 1,0,0,1 repeating; mode 1: random.
  task automatic ready_driver(input int mode);
    int k = 0;
    while (!(done && exp_q.size() == 0)) begin
      if (k >= 600) begin
        chk("ready_timeout", exp_q.size(), 0);
        break;
      end
      out_ready = (mode == 0) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'($urandom_range(1));
      k++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic rand_stream(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
      send_rand();
    end
    done = 1'b1;
  endtask

  initial begin
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, SAT ? 32'h7FFFFFFF : 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, SAT ? 32'h80000000 : 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, SAT ? 32'h80000000 : 32'h00000000, 1'b1, 1'b1, !SAT};
    tbl[8] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{32'h00000003, 32'hFFFFFFFF, 1'b1, 32'h00000004, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {carry_out, overflow, zero}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed vectors back-to-back, no stalls: exact latency checked.
    chk_lat = 1'b1;
    foreach (tbl[i])
      send(tbl[i].a, tbl[i].b, tbl[i].sub,
           exp_t'{tbl[i].es, tbl[i].ec, tbl[i].eo, tbl[i].ez, 0});
    drain();
    chk_lat = 1'b0;

    // Eight back-to-back beats under a 1,0,0,1 out_ready pattern.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        done = 1'b1;
      end
      ready_driver(0);
    join
    drain();

    // Random traffic with input gaps and random backpressure.
    done = 1'b0;
    fork
      rand_stream(80);
      ready_driver(1);
    join
    drain();

    // Reset with beats in flight: nothing may emerge afterwards.
    out_ready = 1'b1;
    repeat (3) send_rand();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("flush_no_valid", out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
